// File: rtl/color_cmd_scheduler_if.sv
// color_cmd_scheduler_if: PS/2 scancode input, VGA blanking input and color/status outputs.
interface color_cmd_scheduler_if;
  logic        key_ready;
  logic [7:0]  scancode;
  logic        vblank;
  logic [11:0] pixel_color;
  logic [2:0]  led;
  logic        cmd_pending;
  logic        overflow;
  modport master (output key_ready, scancode, vblank, input pixel_color, led, cmd_pending, overflow);
  modport slave  (input key_ready, scancode, vblank, output pixel_color, led, cmd_pending, overflow);
endinterface

// File: rtl/color_cmd_scheduler.sv
// color_cmd_scheduler: decodes PS/2 make codes into color commands and applies them only during vblank.
module color_cmd_scheduler #(
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [11:0] DEFAULT_COLOR = 12'h000,
  parameter int          STEP          = 1
) (
  input logic                  clk,
  input logic                  rst,
  color_cmd_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {SEL_R, SEL_G, SEL_B, INC, DEC, CLEAR} cmd_t;
  typedef enum logic {IDLE, BRK} state_t;
  state_t         state;
  logic [2:0]     sync;
  logic           det, mapped, push, pop, full, wr;
  cmd_t           code_cmd, head;
  cmd_t           mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_next;
  logic [4:0]     ch, sum, diff;
  logic [3:0]     nv;
  logic [11:0]    color, color_next;
  logic [2:0]     led_r, led_next;
  logic           pending, ovf;
  assign bus.pixel_color = color;
  assign bus.led         = led_r;
  assign bus.cmd_pending = pending;
  assign bus.overflow    = ovf;
  always_comb begin
    mapped   = 1'b1;
    code_cmd = SEL_R;
    case (bus.scancode)
      8'h2D:        code_cmd = SEL_R;
      8'h34:        code_cmd = SEL_G;
      8'h32:        code_cmd = SEL_B;
      8'h3C, 8'h79: code_cmd = INC;
      8'h23, 8'h7B: code_cmd = DEC;
      8'h29:        code_cmd = CLEAR;
      default:      mapped   = 1'b0;
    endcase
  end
  assign det        = sync[1] & ~sync[2];
  assign push       = det && state == IDLE && mapped;
  assign full       = count == (AW+1)'(FIFO_DEPTH);
  assign pop        = bus.vblank && count != '0;
  assign wr         = push && (!full || pop);
  assign count_next = count + (AW+1)'(wr) - (AW+1)'(pop);
  assign head       = mem[rd_ptr];
  // Channel arithmetic is done in 5 bits so carry/borrow shows up in bit 4 for clamping.
  always_comb begin
    ch         = {1'b0, led_r[0] ? color[11:8] : led_r[1] ? color[7:4] : color[3:0]};
    sum        = ch + 5'(STEP);
    diff       = ch - 5'(STEP);
    nv         = head == INC ? (sum > 5'd15 ? 4'hF : sum[3:0]) : (diff[4] ? 4'h0 : diff[3:0]);
    color_next = head == CLEAR ? DEFAULT_COLOR :
                 (head == INC || head == DEC) ?
                   (led_r[0] ? {nv, color[7:0]} : led_r[1] ? {color[11:8], nv, color[3:0]} : {color[11:4], nv}) :
                 color;
    led_next   = head == SEL_R ? 3'b001 : head == SEL_G ? 3'b010 : head == SEL_B ? 3'b100 : led_r;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      color   <= DEFAULT_COLOR;
      led_r   <= 3'b001;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      sync    <= {sync[1:0], bus.key_ready};
      if (det) state <= (state == IDLE && bus.scancode == 8'hF0) ? BRK : IDLE;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        color  <= color_next;
        led_r  <= led_next;
      end
      count   <= count_next;
      pending <= count_next != '0;
      ovf     <= ovf | (push & full & ~pop);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= code_cmd;
endmodule

// File: tb/tb_color_cmd_scheduler.sv
// tb_color_cmd_scheduler: queue-based reference model plus directed and random keystroke stimulus.
module tb_color_cmd_scheduler;
  localparam int          DEPTH = 4;
  localparam logic [11:0] DEF   = 12'h000;
  localparam int          STEP  = 1;
  logic clk = 0;
  logic rst = 0;
  color_cmd_scheduler_if bus();
  color_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .DEFAULT_COLOR(DEF), .STEP(STEP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, edge_cnt = 0;
  int q[$], pend_edge[$], pend_cmd[$];
  int m_ch[3];
  int m_sel;
  bit m_ovf, m_brk, checking, rand_vb;
  logic [7:0] codes [9] = '{8'h2D, 8'h34, 8'h32, 8'h3C, 8'h79, 8'h23, 8'h7B, 8'h29, 8'h3C};
  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic int map_code(input logic [7:0] c);
    case (c)
      8'h2D: return 0;
      8'h34: return 1;
      8'h32: return 2;
      8'h3C, 8'h79: return 3;
      8'h23, 8'h7B: return 4;
      8'h29: return 5;
      default: return -1;
    endcase
  endfunction
  function automatic void m_reset();
    q.delete(); pend_edge.delete(); pend_cmd.delete();
    m_ch[0] = int'(DEF[11:8]); m_ch[1] = int'(DEF[7:4]); m_ch[2] = int'(DEF[3:0]);
    m_sel = 0; m_ovf = 0; m_brk = 0;
  endfunction
  function automatic int m_color();
    return (m_ch[0] << 8) | (m_ch[1] << 4) | m_ch[2];
  endfunction
  function automatic void apply(input int c);
    if (c < 3) m_sel = c;
    else if (c == 3) m_ch[m_sel] = (m_ch[m_sel] + STEP > 15) ? 15 : m_ch[m_sel] + STEP;
    else if (c == 4) m_ch[m_sel] = (m_ch[m_sel] - STEP < 0) ? 0 : m_ch[m_sel] - STEP;
    else begin
      m_ch[0] = int'(DEF[11:8]); m_ch[1] = int'(DEF[7:4]); m_ch[2] = int'(DEF[3:0]);
    end
  endfunction
  always @(posedge clk) begin
    int c;
    edge_cnt++;
    if (rst) begin
      if (bus.vblank && q.size() > 0) apply(q.pop_front());
      if (pend_edge.size() > 0 && pend_edge[0] == edge_cnt) begin
        void'(pend_edge.pop_front());
        c = pend_cmd.pop_front();
        if (q.size() < DEPTH) q.push_back(c);
        else m_ovf = 1;
      end
    end
  end
  always @(negedge clk) if (rst && checking) begin
    check("pixel_color", int'(bus.pixel_color), m_color());
    check("led", int'(bus.led), 1 << m_sel);
    check("cmd_pending", int'(bus.cmd_pending), int'(q.size() != 0));
    check("overflow", int'(bus.overflow), int'(m_ovf));
  end
  always @(negedge clk) if (rand_vb) bus.vblank = ($urandom_range(0, 9) < 4);
  task automatic send(input logic [7:0] code);
    int c;
    @(negedge clk);
    bus.scancode  = code;
    bus.key_ready = 1;
    c = map_code(code);
    if (m_brk) m_brk = 0;
    else if (code == 8'hF0) m_brk = 1;
    else if (c >= 0) begin
      pend_edge.push_back(edge_cnt + 3);
      pend_cmd.push_back(c);
    end
    repeat ($urandom_range(2, 4)) @(negedge clk);
    bus.key_ready = 0;
    repeat ($urandom_range(3, 5)) @(negedge clk);
  endtask
  initial begin
    bus.key_ready = 0; bus.scancode = 0; bus.vblank = 0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1; checking = 1;
    @(negedge clk);
    check("rst_color", int'(bus.pixel_color), 12'h000);
    check("rst_led", int'(bus.led), 3'b001);
    check("rst_pending", int'(bus.cmd_pending), 0);
    bus.vblank = 1;
    send(8'h34);
    repeat (3) send(8'h3C);
    repeat (6) @(negedge clk);
    check("g_led", int'(bus.led), 3'b010);
    check("g_color", int'(bus.pixel_color), 12'h030);
    send(8'hF0); send(8'h3C);
    repeat (6) @(negedge clk);
    check("break_pending", int'(bus.cmd_pending), 0);
    check("break_color", int'(bus.pixel_color), 12'h030);
    send(8'h2D);
    repeat (20) send(8'h3C);
    repeat (6) @(negedge clk);
    check("sat_hi", int'(bus.pixel_color[11:8]), 4'hF);
    for (int i = 0; i < 20; i++) send(i[0] ? 8'h7B : 8'h23);
    repeat (6) @(negedge clk);
    check("sat_lo", int'(bus.pixel_color[11:8]), 4'h0);
    bus.vblank = 0;
    send(8'h32); send(8'h3C);
    repeat (4) @(negedge clk);
    check("hold_color", int'(bus.pixel_color), 12'h030);
    check("hold_pending", int'(bus.cmd_pending), 1);
    bus.vblank = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("vb_color", int'(bus.pixel_color), 12'h031);
    check("vb_led", int'(bus.led), 3'b100);
    check("vb_pending", int'(bus.cmd_pending), 0);
    bus.vblank = 0;
    send(8'h2D); send(8'h34); send(8'h32); send(8'h3C); send(8'h23); send(8'h29);
    repeat (4) @(negedge clk);
    check("ovf_flag", int'(bus.overflow), 1);
    check("ovf_pending", int'(bus.cmd_pending), 1);
    bus.vblank = 1;
    repeat (6) @(negedge clk);
    check("ovf_led", int'(bus.led), 3'b100);
    check("ovf_color", int'(bus.pixel_color), 12'h032);
    check("ovf_drained", int'(bus.cmd_pending), 0);
    bus.vblank = 0;
    send(8'h2D); send(8'h3C); send(8'h34);
    repeat (2) @(negedge clk);
    check("pre_rst_pending", int'(bus.cmd_pending), 1);
    rst = 0;
    m_reset();
    #1;
    check("arst_color", int'(bus.pixel_color), 12'h000);
    check("arst_led", int'(bus.led), 3'b001);
    check("arst_pending", int'(bus.cmd_pending), 0);
    check("arst_overflow", int'(bus.overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1;
    rand_vb = 1;
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) send(codes[$urandom_range(0, 8)]);
      else if (r == 6) send(8'hF0);
      else if (r == 7) send(8'hE0);
      else send(8'($urandom_range(0, 255)));
    end
    rand_vb = 0;
    bus.vblank = 1;
    repeat (10) @(negedge clk);
    check("final_drain", int'(bus.cmd_pending), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
